// File: rtl/mem_pkg.sv
// Shared definitions for the byte-lane data memory: access sizes, lane count,
// the clear-engine state type and small decode helpers.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int unsigned LANES = 4;

  typedef logic [LANES-1:0] be_t;

  typedef enum logic [0:0] {StClear, StReady} clr_state_e;

  // Lane enables for an access of the given size at byte offset off.
  function automatic be_t lane_enables(input logic [1:0] size, input logic [1:0] off);
    be_t be;
    case (size)
      SZ_B:    be = be_t'(4'b0001 << off);
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Halves need an even offset; words (and the reserved size) need offset 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half from a raw memory word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [31:0] res_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Extract and extend the addressed field.
  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_B:    res_o = {{24{sext_i & byte_v[7]}}, byte_v};
      SZ_H:    res_o = {{16{sext_i & half_v[15]}}, half_v};
      default: res_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_dp_bytelane.sv
// Byte-lane data memory for the MEM stage with a read-only display port.
// Port A (clk) serves CPU loads/stores and the post-reset zero-fill engine;
// port B (dclk) serves the framebuffer reader.
module mem_dp_bytelane
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dclk,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sext_i,
  input  logic [ADDR_WIDTH+1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  misalign_o,
  output logic                  busy_o,
  input  logic [ADDR_WIDTH-1:0] disp_addr_i,
  output logic [DATA_WIDTH-1:0] disp_data_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  logic                  accept, mis, st_fire, ld_fire;
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] a_addr;
  be_t                   a_be;
  logic [31:0]           a_wdata;
  logic [31:0]           st_data;

  logic                  rvalid_q, misalign_q;
  logic [1:0]            ld_size_q, ld_off_q;
  logic                  ld_sext_q;
  logic [31:0]           rd_word;

  assign busy_o  = (state_q == StClear);
  assign off     = addr_i[1:0];
  assign accept  = req_i & ~busy_o;
  assign mis     = is_misaligned(size_i, off);
  assign st_fire = accept & we_i & ~mis;
  assign ld_fire = accept & ~we_i & ~mis;

  // Clear-engine state and word pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? StClear : StReady;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Walk every word once, then hand the port to the CPU.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = StReady;
      end
      StReady: state_d = StReady;
      default: state_d = StReady;
    endcase
  end

  // Port A mux: the clear engine owns the port while busy.
  always_comb begin
    case (size_i)
      SZ_B:    st_data = {4{wdata_i[7:0]}};
      SZ_H:    st_data = {2{wdata_i[15:0]}};
      default: st_data = wdata_i[31:0];
    endcase
    if (busy_o) begin
      a_addr  = ptr_q;
      a_be    = '1;
      a_wdata = '0;
    end else begin
      a_addr  = addr_i[ADDR_WIDTH+1:2];
      a_be    = st_fire ? lane_enables(size_i, off) : '0;
      a_wdata = st_data;
    end
  end

  // Load/misalign pulses and the load attributes that travel with the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      ld_size_q  <= SZ_W;
      ld_off_q   <= 2'd0;
      ld_sext_q  <= 1'b0;
    end else begin
      rvalid_q   <= ld_fire;
      misalign_q <= accept & mis;
      if (ld_fire) begin
        ld_size_q <= size_i;
        ld_off_q  <= off;
        ld_sext_q <= sext_i;
      end
    end
  end

  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    logic [7:0] mem_q [Depth];
    logic [7:0] rd_q;
    logic [7:0] disp_q;

    // Port A byte write.
    always_ff @(posedge clk) begin
      if (a_be[gl]) mem_q[a_addr] <= a_wdata[8*gl +: 8];
    end

    // Port A registered read; holds between loads so rdata holds too.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)          rd_q <= '0;
      else if (ld_fire) rd_q <= mem_q[a_addr];
    end

    // Port B registered read in the display domain.
    always_ff @(posedge dclk or posedge rst) begin
      if (rst) disp_q <= '0;
      else     disp_q <= mem_q[disp_addr_i];
    end

    assign rd_word[8*gl +: 8]     = rd_q;
    assign disp_data_o[8*gl +: 8] = disp_q;
  end

  mem_load_align u_align (
    .word_i (rd_word),
    .off_i  (ld_off_q),
    .size_i (ld_size_q),
    .sext_i (ld_sext_q),
    .res_o  (rdata_o)
  );

  assign rvalid_o   = rvalid_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_dp_bytelane.sv
// Directed and randomized bench for mem_dp_bytelane against a byte-array model.
module tb_mem_dp_bytelane;

  logic        clk = 1'b0;
  logic        dclk = 1'b0;
  logic        rst;
  logic        req, we, sext;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata, rdata, disp_data;
  logic        rvalid, misalign, busy;
  logic [9:0]  disp_addr;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mm [4096];
  logic [31:0] last_rd;

  always #5 clk = ~clk;
  always #7 dclk = ~dclk;

  mem_dp_bytelane #(
    .ADDR_WIDTH     (10),
    .DATA_WIDTH     (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dclk        (dclk),
    .req_i       (req),
    .we_i        (we),
    .size_i      (size),
    .sext_i      (sext),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .misalign_o  (misalign),
    .busy_o      (busy),
    .disp_addr_i (disp_addr),
    .disp_data_o (disp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [11:0] a);
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  // Little-endian assembly of the addressed bytes, then extension.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sx,
                                             input logic [11:0] a);
    longint val = 0;
    int n = nbytes(sz);
    for (int i = n - 1; i >= 0; i--) val = val * 256 + longint'(mm[int'(a) + i]);
    if (sx && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
    return 32'(val);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < nbytes(sz); i++) begin
      t = wd >> (8 * i);
      mm[int'(a) + i] = t[7:0];
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
    last_rd = 32'h0;
  endtask

  // One request; called on a clk negedge, returns on the next negedge.
  task automatic do_op(input string tag, input bit w, input logic [1:0] sz, input bit sx,
                       input logic [11:0] a, input logic [31:0] wd);
    bit m;
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    m = model_mis(sz, a);
    if (!w && !m) last_rd = model_load(sz, sx, a);
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m});
    chk({tag, ".rvalid"}, {31'b0, rvalid}, {31'b0, (!w && !m)});
    chk({tag, ".rdata"}, rdata, last_rd);
    if (w && !m) model_store(sz, a, wd);
  endtask

  // Counts busy cycles after reset release; optionally fires requests mid-clear.
  task automatic count_busy(input bit stall_reqs, output int cnt, output int pulses);
    cnt = 0;
    pulses = 0;
    while (busy && cnt < 5000) begin
      if (stall_reqs && cnt >= 900 && cnt < 1000) begin
        req = 1'b1;
        case (cnt % 3)
          0: begin we = 1'b1; size = 2'd2; addr = 12'h000; wdata = 32'hDEADBEEF; end
          1: begin we = 1'b0; size = 2'd2; addr = 12'h000; end
          default: begin we = 1'b0; size = 2'd2; addr = 12'h001; end
        endcase
      end else begin
        req = 1'b0;
      end
      cnt++;
      @(negedge clk);
      if (rvalid || misalign) pulses++;
    end
    req = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    int cnt, pulses, wsel;
    logic [1:0]  sz;
    logic [11:0] a;
    bit w, sx;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0;
    addr = '0; wdata = '0; disp_addr = '0;
    model_clear();
    #23;
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst.misalign", {31'b0, misalign}, 32'h0);
    chk("rst.disp_data", disp_data, 32'h0);
    chk("rst.busy", {31'b0, busy}, 32'h1);

    @(negedge clk);
    rst = 1'b0;
    count_busy(1'b0, cnt, pulses);
    chk("clear.cycles", 32'(cnt), 32'd1024);
    do_op("lw_3ff", 1'b0, 2'd2, 1'b0, 12'hFFC, 32'h0);
    chk("lw_3ff.lit", rdata, 32'h0);

    // Byte lanes, including a load right behind a store.
    do_op("sw10", 1'b1, 2'd2, 1'b0, 12'h010, 32'h11223344);
    do_op("sb12", 1'b1, 2'd0, 1'b0, 12'h012, 32'h000000AA);
    do_op("lw10", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    chk("lw10.lit", rdata, 32'h11AA3344);
    do_op("lbu13", 1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    chk("lbu13.lit", rdata, 32'h00000011);
    do_op("lb12", 1'b0, 2'd0, 1'b1, 12'h012, 32'h0);
    chk("lb12.lit", rdata, 32'hFFFFFFAA);

    // Halves.
    do_op("sw20", 1'b1, 2'd2, 1'b0, 12'h020, 32'h12345678);
    do_op("sh22", 1'b1, 2'd1, 1'b0, 12'h022, 32'h00008001);
    do_op("lh22", 1'b0, 2'd1, 1'b1, 12'h022, 32'h0);
    chk("lh22.lit", rdata, 32'hFFFF8001);
    do_op("lhu22", 1'b0, 2'd1, 1'b0, 12'h022, 32'h0);
    chk("lhu22.lit", rdata, 32'h00008001);
    do_op("lw20", 1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
    chk("lw20.lit", rdata, 32'h80015678);

    // Misaligned accesses are rejected without side effects.
    do_op("sw30", 1'b1, 2'd2, 1'b0, 12'h030, 32'h55667788);
    do_op("sw31", 1'b1, 2'd2, 1'b0, 12'h031, 32'hCAFEF00D);
    do_op("lh33", 1'b0, 2'd1, 1'b0, 12'h033, 32'h0);
    do_op("lw30", 1'b0, 2'd2, 1'b0, 12'h030, 32'h0);
    chk("lw30.lit", rdata, 32'h55667788);

    // Display port.
    do_op("sw14", 1'b1, 2'd2, 1'b0, 12'h014, 32'h00FF00FF);
    @(negedge clk);
    @(negedge dclk);
    disp_addr = 10'd5;
    @(posedge dclk);
    #1;
    chk("disp5", disp_data, 32'h00FF00FF);

    // Randomized traffic in a small window so loads hit stored data.
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      a  = 12'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a - 12'(int'(a) % nbytes(sz));
      do_op("rnd", w, sz, sx, a, $urandom);
    end

    for (int i = 0; i < 16; i++) begin
      wsel = $urandom_range(0, 63);
      @(negedge dclk);
      disp_addr = 10'(wsel);
      @(posedge dclk);
      #1;
      chk("disp_rnd", disp_data, model_word(wsel));
    end

    // Reset in the middle of a clear restarts it from the first word.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 500; i++) @(negedge clk);
    chk("midclear.busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #2;
    chk("midclear.rst_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    count_busy(1'b1, cnt, pulses);
    chk("restart.cycles", 32'(cnt), 32'd1024);
    chk("stall.pulses", 32'(pulses), 32'd0);
    do_op("lw0_after", 1'b0, 2'd2, 1'b0, 12'h000, 32'h0);
    chk("lw0_after.lit", rdata, 32'h0);
    do_op("lw30_after", 1'b0, 2'd2, 1'b0, 12'h030, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
